// File: rtl/io_input_debounce_pkg.sv
// io_pkg: shared constants for the IO input front end and its memory-mapped registers
package io_pkg;
  localparam int IO_WIDTH = 32;
  localparam logic [15:0] IO_SW_ADDR = 16'h7800;
  localparam logic [15:0] IO_BTN_ADDR = 16'h7810;
  localparam int DB_CYCLES_DEFAULT = 250000;
  localparam int DB_CYCLES_SIM = 4;
endpackage

// File: rtl/io_input_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stability counter for one pad bit
module debounce_bit #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic s1_q, s2_q, st_q, st_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  // accept s2 once it has differed from st for DB_CYCLES consecutive edges; any agreement restarts the count
  always_comb begin
    hit = (s2_q != st_q) && (cnt_q == CW'(DB_CYCLES - 1));
    st_d = hit ? s2_q : st_q;
    cnt_d = (s2_q == st_q || hit) ? '0 : cnt_q + CW'(1);
  end
  // synchroniser, stable level and counter state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      st_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= i_raw;
      s2_q <= s1_q;
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_stable = st_q;
  assign o_rise = hit & s2_q;
  assign o_fall = hit & ~s2_q;
endmodule

// File: rtl/io_input_debounce.sv
// io_input_debounce: synchronise, debounce and normalise board switches and buttons
module io_input_debounce
  import io_pkg::*;
#(
  parameter int NUM_SW = 18,
  parameter int NUM_BTN = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_SW-1:0]   i_sw_raw,
  input  logic [NUM_BTN-1:0]  i_btn_raw,
  output logic [IO_WIDTH-1:0] o_io_sw,
  output logic [IO_WIDTH-1:0] o_io_btn,
  output logic [IO_WIDTH-1:0] o_btn_press,
  output logic                o_sw_change
);
  if (NUM_SW < 1 || NUM_SW > 32 || NUM_BTN < 1 || NUM_BTN > 32 || DB_CYCLES < 1) begin : g_bad_params
    $error("io_input_debounce: NUM_SW/NUM_BTN must be 1..32 and DB_CYCLES >= 1");
  end
  logic [NUM_SW-1:0] sw_st, sw_rise, sw_fall;
  logic [NUM_BTN-1:0] btn_in, btn_st, btn_rise, unused_btn_fall, press_q;
  logic sw_change_q;
  // inverting before the synchroniser makes the idle button level reset-equivalent, so no press after reset
  assign btn_in = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_sw_raw[i]),
      .o_stable(sw_st[i]), .o_rise(sw_rise[i]), .o_fall(sw_fall[i])
    );
  end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk(i_clk), .i_rst(i_rst), .i_raw(btn_in[i]),
      .o_stable(btn_st[i]), .o_rise(btn_rise[i]), .o_fall(unused_btn_fall[i])
    );
  end
  // event pulses register on the same edge the stable bits toggle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_q <= '0;
      sw_change_q <= 1'b0;
    end else begin
      press_q <= btn_rise;
      sw_change_q <= |{sw_rise, sw_fall};
    end
  end
  assign o_io_sw = IO_WIDTH'(sw_st);
  assign o_io_btn = IO_WIDTH'(btn_st);
  assign o_btn_press = IO_WIDTH'(press_q);
  assign o_sw_change = sw_change_q;
endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed checks of debounce latency, glitch rejection, pulses and async reset
module tb_io_input_debounce;
  import io_pkg::*;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [17:0] i_sw_raw = 18'h3FFFF;
  logic [3:0] i_btn_raw = 4'hF;
  logic [31:0] o_io_sw, o_io_btn, o_btn_press;
  logic o_sw_change;
  int total = 0, passed = 0;
  io_input_debounce #(.NUM_SW(18), .NUM_BTN(4), .DB_CYCLES(DB_CYCLES_SIM), .BTN_ACTIVE_LOW(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sw_raw(i_sw_raw), .i_btn_raw(i_btn_raw),
    .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press), .o_sw_change(o_sw_change)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic test_reset();
    tick(3);
    total++; if ({o_io_sw, o_io_btn, o_btn_press, o_sw_change} !== 97'd0) $display("FAIL reset_outputs: got sw=%h btn=%h press=%h chg=%b expected all 0", o_io_sw, o_io_btn, o_btn_press, o_sw_change); else passed++;
    i_rst = 1'b0;
    i_sw_raw = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      total++; if (o_io_btn !== 32'h0 || o_btn_press !== 32'h0) $display("FAIL idle_btn_after_reset: cycle %0d got btn=%h press=%h expected 0/0", i, o_io_btn, o_btn_press); else passed++;
    end
    total++; if (o_io_sw !== 32'h0 || o_sw_change !== 1'b0) $display("FAIL idle_sw_after_reset: got sw=%h chg=%b expected 0/0", o_io_sw, o_sw_change); else passed++;
  endtask
  task automatic test_switch_latency();
    i_sw_raw = 18'h00005;
    tick(5);
    total++; if (o_io_sw !== 32'h0 || o_sw_change !== 1'b0) $display("FAIL sw_before_edge6: got sw=%h chg=%b expected 0/0", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h5 || o_sw_change !== 1'b1) $display("FAIL sw_at_edge6: got sw=%h chg=%b expected 5/1", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h5 || o_sw_change !== 1'b0) $display("FAIL sw_after_edge6: got sw=%h chg=%b expected 5/0", o_io_sw, o_sw_change); else passed++;
  endtask
  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      i_btn_raw = 4'hE;
      for (int c = 0; c < 5; c++) begin
        if (c == 3) i_btn_raw = 4'hF;
        tick(1);
        total++; if (o_io_btn !== 32'h0 || o_btn_press !== 32'h0) $display("FAIL bounce: rep %0d cycle %0d got btn=%h press=%h expected 0/0", r, c, o_io_btn, o_btn_press); else passed++;
      end
    end
    tick(6);
    total++; if (o_io_btn !== 32'h0) $display("FAIL bounce_settled: got btn=%h expected 0", o_io_btn); else passed++;
  endtask
  task automatic test_clean_press();
    i_btn_raw = 4'hE;
    tick(5);
    total++; if (o_io_btn !== 32'h0 || o_btn_press !== 32'h0) $display("FAIL press_before_edge6: got btn=%h press=%h expected 0/0", o_io_btn, o_btn_press); else passed++;
    tick(1);
    total++; if (o_io_btn !== 32'h1 || o_btn_press !== 32'h1) $display("FAIL press_at_edge6: got btn=%h press=%h expected 1/1", o_io_btn, o_btn_press); else passed++;
    for (int c = 7; c <= 20; c++) begin
      tick(1);
      total++; if (o_io_btn !== 32'h1 || o_btn_press !== 32'h0) $display("FAIL press_held: edge %0d got btn=%h press=%h expected 1/0", c, o_io_btn, o_btn_press); else passed++;
    end
    i_btn_raw = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      total++; if (o_io_btn !== (c < 6 ? 32'h1 : 32'h0) || o_btn_press !== 32'h0) $display("FAIL release: edge %0d got btn=%h press=%h expected %h/0", c, o_io_btn, o_btn_press, (c < 6 ? 32'h1 : 32'h0)); else passed++;
    end
    total++; if (o_sw_change !== 1'b0 || o_io_sw !== 32'h5) $display("FAIL sw_quiet_during_btn: got sw=%h chg=%b expected 5/0", o_io_sw, o_sw_change); else passed++;
  endtask
  task automatic test_async_reset();
    i_btn_raw = 4'hD;
    tick(3);
    i_rst = 1'b1;
    #1;
    total++; if ({o_io_sw, o_io_btn, o_btn_press, o_sw_change} !== 97'd0) $display("FAIL async_reset_immediate: got sw=%h btn=%h press=%h chg=%b expected all 0", o_io_sw, o_io_btn, o_btn_press, o_sw_change); else passed++;
    tick(2);
    i_rst = 1'b0;
    tick(5);
    total++; if (o_io_btn !== 32'h0 || o_io_sw !== 32'h0) $display("FAIL requalify_edge5: got btn=%h sw=%h expected 0/0", o_io_btn, o_io_sw); else passed++;
    tick(1);
    total++; if (o_io_btn !== 32'h2 || o_btn_press !== 32'h2 || o_io_sw !== 32'h5 || o_sw_change !== 1'b1) $display("FAIL requalify_edge6: got btn=%h press=%h sw=%h chg=%b expected 2/2/5/1", o_io_btn, o_btn_press, o_io_sw, o_sw_change); else passed++;
    i_btn_raw = 4'hF;
    i_sw_raw = '0;
    tick(8);
    total++; if (o_io_btn !== 32'h0 || o_io_sw !== 32'h0 || o_sw_change !== 1'b0) $display("FAIL back_to_idle: got btn=%h sw=%h chg=%b expected 0/0/0", o_io_btn, o_io_sw, o_sw_change); else passed++;
  endtask
  task automatic test_staggered();
    i_sw_raw = 18'h00001;
    tick(2);
    i_sw_raw = 18'h00003;
    tick(3);
    total++; if (o_io_sw !== 32'h0 || o_sw_change !== 1'b0) $display("FAIL stagger_t5: got sw=%h chg=%b expected 0/0", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h1 || o_sw_change !== 1'b1) $display("FAIL stagger_t6: got sw=%h chg=%b expected 1/1", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h1 || o_sw_change !== 1'b0) $display("FAIL stagger_t7: got sw=%h chg=%b expected 1/0", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h3 || o_sw_change !== 1'b1) $display("FAIL stagger_t8: got sw=%h chg=%b expected 3/1", o_io_sw, o_sw_change); else passed++;
    tick(1);
    total++; if (o_io_sw !== 32'h3 || o_sw_change !== 1'b0) $display("FAIL stagger_t9: got sw=%h chg=%b expected 3/0", o_io_sw, o_sw_change); else passed++;
  endtask
  initial begin
    test_reset();
    test_switch_latency();
    test_bounce();
    test_clean_press();
    test_async_reset();
    test_staggered();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
